// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
//
// Owns the three obstacle slots that the VGA renderer draws. On every
// running-mode frame tick a short walk visits each slot once (move left by
// SPEED, retire at the left edge) and then tries to spawn a new obstacle at
// a pseudo-random height.
//
// Ports
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame (start of vertical blank)
//   gamemode      00 init, 01 running, 10 paused, 11 ended
//   obstacle_x    slot i x_left at [i*10 +: 10], 10'h3FF when inactive
//   obstacle_y    slot i y_top  at [i*9 +: 9],   9'd0 when inactive
//   active_count  number of active slots (0..3)
//   busy          high while a frame update walk is in progress

module obstacle_scheduler #(
    parameter int unsigned SPEED     = 4,
    parameter int unsigned SPAWN_GAP = 45,
    parameter int unsigned SPAWN_X   = 640,
    parameter int unsigned Y_MIN     = 20,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [1:0]  gamemode,
    output logic [29:0] obstacle_x,
    output logic [26:0] obstacle_y,
    output logic [1:0]  active_count,
    output logic        busy
);

    localparam int unsigned GAP_W   = (SPAWN_GAP > 2) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SPAWN_GAP - 1);
    localparam logic [9:0]  X_OFF    = 10'h3FF;
    localparam logic [9:0]  SPEED_X  = 10'(SPEED);
    localparam logic [9:0]  SPAWN_XV = 10'(SPAWN_X);
    localparam logic [8:0]  Y_MIN_V  = 9'(Y_MIN);
    localparam logic [1:0]  MODE_INIT = 2'b00;
    localparam logic [1:0]  MODE_RUN  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_SPAWN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        act;
    logic [2:0]        act_next;
    logic [9:0]        x_q    [3];
    logic [9:0]        x_next [3];
    logic [8:0]        y_q    [3];
    logic [8:0]        y_next [3];
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_next;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [15:0]       lfsr_step;
    logic [8:0]        spawn_off;
    logic [2:0]        move_sel;
    logic              spawn_done;
    logic [1:0]        count_next;
    logic              busy_next;

    // Walk sequencer. Init mode aborts any walk immediately; otherwise a walk
    // only starts from IDLE on a running-mode tick and, once started, always
    // runs to completion so a frame update is never seen half-applied.
    always_comb begin
        state_next = state;
        if (gamemode == MODE_INIT) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (frame_tick && gamemode == MODE_RUN) state_next = S_M0;
                S_M0:    state_next = S_M1;
                S_M1:    state_next = S_M2;
                S_M2:    state_next = S_SPAWN;
                S_SPAWN: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Slot, spawn-gap and LFSR update. Each move state touches exactly one
    // slot; retired slots are parked at the off-screen value so the output
    // buses can be driven straight from the slot registers. The spawn step
    // sees the slots as already moved, so a slot freed earlier in the walk
    // is immediately reusable.
    always_comb begin
        act_next   = act;
        x_next     = x_q;
        y_next     = y_q;
        gap_next   = gap_cnt;
        lfsr_next  = lfsr;
        spawn_done = 1'b0;
        move_sel   = {state == S_M2, state == S_M1, state == S_M0};
        lfsr_step  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        spawn_off  = lfsr[8:0];
        if (spawn_off > 9'd400) begin
            spawn_off = spawn_off - 9'd256;
        end

        if (gamemode == MODE_INIT) begin
            act_next = 3'b000;
            for (int k = 0; k < 3; k++) begin
                x_next[k] = X_OFF;
                y_next[k] = 9'd0;
            end
            gap_next = GAP_MAX;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (move_sel[k] && act[k]) begin
                    if (x_q[k] < SPEED_X) begin
                        act_next[k] = 1'b0;
                        x_next[k]   = X_OFF;
                        y_next[k]   = 9'd0;
                    end else begin
                        x_next[k] = x_q[k] - SPEED_X;
                    end
                end
            end

            if (state == S_SPAWN) begin
                lfsr_next = lfsr_step;
                if (gap_cnt == GAP_MAX && act != 3'b111) begin
                    for (int k = 0; k < 3; k++) begin
                        if (!spawn_done && !act[k]) begin
                            act_next[k] = 1'b1;
                            x_next[k]   = SPAWN_XV;
                            y_next[k]   = Y_MIN_V + spawn_off;
                            spawn_done  = 1'b1;
                        end
                    end
                    gap_next = '0;
                end else if (gap_cnt < GAP_MAX) begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
        end

        count_next = {1'b0, act_next[0]} + {1'b0, act_next[1]} + {1'b0, act_next[2]};
        busy_next  = (gamemode != MODE_INIT) && (state != S_IDLE);
    end

    // State register. busy lags the sequencer by one cycle so it is high
    // exactly across the four edges at which the walk writes results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            act          <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                x_q[k] <= X_OFF;
                y_q[k] <= 9'd0;
            end
            gap_cnt      <= GAP_MAX;
            lfsr         <= LFSR_SEED;
            active_count <= 2'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            act          <= act_next;
            x_q          <= x_next;
            y_q          <= y_next;
            gap_cnt      <= gap_next;
            lfsr         <= lfsr_next;
            active_count <= count_next;
            busy         <= busy_next;
        end
    end

    assign obstacle_x = {x_q[2], x_q[1], x_q[0]};
    assign obstacle_y = {y_q[2], y_q[1], y_q[0]};

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler
//
// Drives obstacle_scheduler with directed frame sequences and randomized
// gamemode/tick patterns, comparing its buses against a frame-level model
// of the slots kept in plain integers.

module tb_obstacle_scheduler;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic [1:0]  gamemode;
    logic [29:0] obstacle_x;
    logic [26:0] obstacle_y;
    logic [1:0]  active_count;
    logic        busy;

    int checks;
    int errors;

    bit          m_act [3];
    int          m_x   [3];
    int          m_y   [3];
    int          m_gap;
    logic [15:0] m_lfsr;

    obstacle_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .gamemode     (gamemode),
        .obstacle_x   (obstacle_x),
        .obstacle_y   (obstacle_y),
        .active_count (active_count),
        .busy         (busy)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a run that never finishes.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the end of the run");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Frame-level model: a whole walk is one move of every slot followed by
    // one spawn attempt.
    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 1'b0;
            m_x[k]   = 0;
            m_y[k]   = 0;
        end
        m_gap  = 44;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) m_act[k] = 1'b0;
        m_gap = 44;
    endtask

    task automatic model_move();
        for (int k = 0; k < 3; k++) begin
            if (m_act[k]) begin
                if (m_x[k] < 4) m_act[k] = 1'b0;
                else            m_x[k]   = m_x[k] - 4;
            end
        end
    endtask

    task automatic model_spawn();
        int off;
        int slot;
        slot = -1;
        for (int k = 2; k >= 0; k--) if (!m_act[k]) slot = k;
        off = int'(m_lfsr) % 512;
        if (off > 400) off = off - 256;
        if (m_gap == 44 && slot >= 0) begin
            m_act[slot] = 1'b1;
            m_x[slot]   = 640;
            m_y[slot]   = 20 + off;
            m_gap       = 0;
        end else begin
            m_gap = (m_gap + 1 > 44) ? 44 : m_gap + 1;
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    function automatic logic [29:0] exp_x();
        logic [29:0] b;
        for (int k = 0; k < 3; k++) b[k*10 +: 10] = m_act[k] ? 10'(m_x[k]) : 10'h3FF;
        return b;
    endfunction

    function automatic logic [26:0] exp_y();
        logic [26:0] b;
        for (int k = 0; k < 3; k++) b[k*9 +: 9] = m_act[k] ? 9'(m_y[k]) : 9'd0;
        return b;
    endfunction

    function automatic logic [1:0] exp_count();
        int n;
        n = 0;
        for (int k = 0; k < 3; k++) n += m_act[k] ? 1 : 0;
        return 2'(n);
    endfunction

    task automatic check_all(input string tag);
        checkOutput({tag, "_x"},     32'(obstacle_x),   32'(exp_x()));
        checkOutput({tag, "_y"},     32'(obstacle_y),   32'(exp_y()));
        checkOutput({tag, "_count"}, 32'(active_count), 32'(exp_count()));
    endtask

    // One frame: pulse frame_tick under the given mode, follow the walk edge
    // by edge, then idle. Optionally re-pulse the tick mid-walk or pause the
    // game mid-walk; neither may disturb the walk.
    task automatic applyStimulus(input logic [1:0] mode, input bit retrig,
                                 input bit pause_mid, input int idle);
        logic [29:0] pre_x;
        logic [29:0] mv_x;
        logic [29:0] e_x;
        bit          running;
        running = (mode == 2'b01);
        pre_x   = exp_x();
        mv_x    = pre_x;
        if (running) begin
            model_move();
            mv_x = exp_x();
            model_spawn();
        end else if (mode == 2'b00) begin
            model_clear();
        end
        gamemode   = mode;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            frame_tick = (retrig && i == 2);
            if (pause_mid && i == 2) gamemode = 2'b10;
            @(negedge clk);
            checkOutput($sformatf("busy_e%0d", i), 32'(busy), 32'(running && i <= 4));
            if (running && i <= 3) begin
                for (int k = 0; k < 3; k++)
                    e_x[k*10 +: 10] = (k < i) ? mv_x[k*10 +: 10] : pre_x[k*10 +: 10];
                checkOutput($sformatf("walk_x_e%0d", i), 32'(obstacle_x), 32'(e_x));
            end
        end
        frame_tick = 1'b0;
        check_all("frame");
        repeat (idle) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_x"},     32'(obstacle_x),   32'h3FFF_FFFF);
        checkOutput({tag, "_y"},     32'(obstacle_y),   32'd0);
        checkOutput({tag, "_count"}, 32'(active_count), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),         32'd0);
    endtask

    initial begin
        logic [1:0] mode;
        int         r;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        gamemode   = 2'b01;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // First spawn lands in slot 0 at the seed-derived height.
        applyStimulus(2'b01, 1'b0, 1'b0, 1);
        checkOutput("tick1_x0", 32'(obstacle_x[9:0]), 32'd640);
        checkOutput("tick1_y0", 32'(obstacle_y[8:0]), 32'd245);
        checkOutput("tick1_count", 32'(active_count), 32'd1);
        applyStimulus(2'b01, 1'b1, 1'b0, 0);
        checkOutput("tick2_x0", 32'(obstacle_x[9:0]), 32'd636);
        checkOutput("tick2_x12", 32'(obstacle_x[29:10]), 32'hFFFFF);

        // Fill all slots, saturate the gap, retire slot 0 at the left edge.
        for (int t = 3; t <= 162; t++) applyStimulus(2'b01, 1'b0, 1'b0, 0);
        checkOutput("tick162_x0", 32'(obstacle_x[9:0]), 32'd640);
        checkOutput("tick162_count", 32'(active_count), 32'd3);

        // Paused: nothing moves, busy stays low.
        for (int t = 0; t < 10; t++) applyStimulus(2'b10, 1'b0, 1'b0, 1);
        applyStimulus(2'b01, 1'b0, 1'b0, 0);

        // Randomized mode / tick patterns.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 14 || r == 15) mode = 2'b10;
            else if (r == 16)       mode = 2'b11;
            else if (r == 17)       mode = 2'b00;
            else                    mode = 2'b01;
            applyStimulus(mode, ($urandom_range(0, 3) == 0),
                          (mode == 2'b01) && ($urandom_range(0, 5) == 0),
                          int'($urandom_range(0, 3)));
        end

        // Init mode during M1 aborts the walk on the next edge.
        gamemode   = 2'b01;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        gamemode = 2'b00;
        @(negedge clk);
        model_clear();
        check_reset_values("abort");
        applyStimulus(2'b01, 1'b0, 1'b0, 0);
        checkOutput("abort_respawn_count", 32'(active_count), 32'd1);

        // Asynchronous reset mid-walk, then the seed sequence restarts.
        for (int t = 0; t < 5; t++) applyStimulus(2'b01, 1'b0, 1'b0, 0);
        gamemode   = 2'b01;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        applyStimulus(2'b01, 1'b0, 1'b0, 0);
        checkOutput("reseed_y0", 32'(obstacle_y[8:0]), 32'd245);
        checkOutput("reseed_x0", 32'(obstacle_x[9:0]), 32'd640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Frame-rate controller that owns the three obstacle slots consumed by the VGA pixel renderer. On each running-mode frame tick it moves active obstacles left, retires obstacles that reach the left edge, and spawns new ones at pseudo-random heights. It drives the packed `obstacle_x`/`obstacle_y` buses that feed the renderer. It sits between `game_logic` (which supplies `gamemode`) and the renderer, and is clocked in the pixel clock domain.

## Interface
- `SPEED`, 4: pixels moved left per frame.
- `SPAWN_GAP`, 45: minimum frames between spawns.
- `SPAWN_X`, 640: x_left of a newly spawned obstacle.
- `Y_MIN`, 20: smallest spawn y_top.
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR (must be nonzero).

- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `frame_tick`  in  1  one-cycle pulse per frame (start of vertical blank)
- `gamemode`  in  2  00 init, 01 running, 10 paused, 11 ended
- `obstacle_x`  out  30  slot i x_left at `[i*10 +: 10]`, registered
- `obstacle_y`  out  27  slot i y_top at `[i*9 +: 9]`, registered
- `active_count`  out  2  number of active slots, 0–3
- `busy`  out  1  high while a frame update walk is in progress

## Operation
- Per-slot state: `act`, `x[9:0]`, `y[8:0]`. An inactive slot outputs x=10'h3FF and y=9'd0; these values are off-screen for the renderer.
- FSM states:
  - IDLE → M0 on `frame_tick && gamemode==01`.
  - M0 → M1 → M2 → SPAWN → IDLE, one cycle each.
  - `frame_tick` in any state other than IDLE is ignored.
- Mk (move slot k): if `act` and x < SPEED, clear `act`. Else if `act`, x ← x − SPEED. Inactive slots are untouched.
- SPAWN:
  - Spawn fires if `gap_cnt == SPAWN_GAP−1` and any slot is free. The lowest-index free slot gets `act`=1, x=SPAWN_X, y=Y_MIN+off, and `gap_cnt` ← 0.
  - off = lfsr[8:0]; if off > 400, off −= 256 (result lies in 0..400, so y lies in 20..420).
  - If no spawn fires, `gap_cnt` ← min(`gap_cnt`+1, SPAWN_GAP−1). Saturation means a spawn is retried on every later tick until a slot frees.
  - The LFSR advances once at SPAWN, whether or not a spawn fires.
  - A slot freed in M0–M2 is reusable in the same walk's SPAWN.
- LFSR: 16-bit Galois, lfsr ← (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It changes only at SPAWN.
- gamemode 00 has priority, evaluated every cycle:
  - All slots are cleared and the FSM returns to IDLE, aborting any walk.
  - `gap_cnt` ← SPAWN_GAP−1.
  - The LFSR is not reset.
- gamemode 10 or 11: no new walk starts and state is held. A walk already in progress completes, so a frame update is atomic.
- `active_count` is a registered popcount of `act`, updated with the slots.

## Timing
- Reset: all `act`=0, `obstacle_x`=30'h3FFF_FFFF, `obstacle_y`=0, `active_count`=0, `busy`=0, FSM=IDLE, `gap_cnt`=SPAWN_GAP−1, lfsr=LFSR_SEED.
- Latency from `frame_tick` sampled high at edge t:
  - `busy`=1 from t+1 through t+4.
  - Slot k outputs update at edge t+1+k.
  - The spawned slot and `active_count` are final at edge t+4.
  - `busy`=0 at t+5.
- Bus outputs change only during the walk. The renderer samples them during active video, which must start ≥5 cycles after `frame_tick`.
- Width rules:
  - x never exceeds 640 (fits 10 bits); subtraction happens only when x ≥ SPEED, so it never underflows.
  - y_top ≤ 420, so y_top+40 ≤ 460 (fits 9 bits).
- Asynchronous reset mid-walk returns every output to its reset value immediately.

## Test plan
- Reset, gamemode=01, tick 1 → slot0 x=640, y=245 (0x0E1=225 + 20), `active_count`=1. Tick 2 → slot0 x=636. Slots 1–2 read 3FF/0.
- Ticks 1..136 running → spawns at ticks 1, 46, 91 (slots 0, 1, 2). At tick 136 no slot is free and `gap_cnt` holds at 44. Slot0 reaches x=0 at tick 161, frees at tick 162, and is respawned at x=640 in that same walk. `active_count` stays 3.
- Running, gamemode→10 for 10 ticks → outputs unchanged and `busy` never rises. Back to 01 → movement resumes at −4 per tick.
- gamemode driven 00 during M1 of a walk (`busy`=1) → next edge: all slots read 3FF/0, `busy`=0, `active_count`=0. The next running tick spawns immediately.
- `frame_tick` pulsed again at t+2 during a walk → ignored; each slot moves by exactly 4.
- `rst_n` asserted asynchronously mid-walk (no clock edge) → outputs reach reset values before the next edge. After release, the LFSR restarts at 16'hACE1 and the first spawn y is again 245.
